dlx_mem_stage_p: RTL and testbench
==================================

DLX_MEM_STAGE_P -- requirements
Module: dlx_mem_stage_p

Interface
REQ-001 Parameter DATA_W, default 32, data/word width in bits; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter REG_W, default 5, destination-register index width.
REQ-004 Parameter SHADOW_DEPTH, default 3, number of instructions squashed after a branch; SHALL be 0..15.
REQ-005 One clock; reset is synchronous and active-high. Ports are listed below as name, direction, width, meaning.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  reset.
REQ-008 ex_valid  in  1  EX presents an instruction.
REQ-009 ex_mem_rd, ex_mem_wr  in  1 each  load / store request.
REQ-010 ex_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64).
REQ-011 ex_unsigned  in  1  zero-extend load when 1, sign-extend when 0.
REQ-012 ex_addr  in  ADDR_W  ALU result / effective address.
REQ-013 ex_wdata  in  DATA_W  store data, right-justified.
REQ-014 ex_memtoreg, ex_regwrite, ex_branch  in  1 each  control from EX.
REQ-015 ex_towrite  in  REG_W  destination register.
REQ-016 mem_req, mem_we  out  1 each  memory request and write strobe.
REQ-017 mem_be  out  DATA_W/8  byte enables.
REQ-018 mem_addr  out  ADDR_W  word-aligned address (low log2(DATA_W/8) bits zero).
REQ-019 mem_wdata  out  DATA_W  lane-replicated store data.
REQ-020 mem_rdata  in  DATA_W; mem_ack  in  1  completion.
REQ-021 stall  out  1  EX must hold its inputs.
REQ-022 wb_valid, wb_memtoreg, wb_regwrite  out  1 each; wb_towrite  out  REG_W; wb_result, wb_rdata  out  DATA_W.
REQ-023 branch_shadow  out  1  squash window active; misalign  out  1  one-cycle fault pulse.

Function
REQ-024 An instruction SHALL be accepted on an edge where ex_valid=1 and stall=0.
REQ-025 A non-memory instruction SHALL appear on wb_* one cycle after acceptance, with wb_result=ex_addr.
REQ-026 The FSM SHALL have states IDLE and BUSY; an accepted non-squashed, aligned load/store SHALL move IDLE->BUSY.
REQ-027 In BUSY, mem_* SHALL be registered, stable and asserted from the cycle after acceptance until the mem_ack cycle inclusive; stall SHALL equal (state==BUSY).
REQ-028 On the mem_ack edge, the FSM SHALL return to IDLE and wb_valid SHALL pulse for one cycle; minimum load-to-WB latency is 2 cycles.
REQ-029 Load data SHALL be taken from the addressed lane, shifted to bit 0, and extended from bit 8*size_bytes-1 (sign) or with zeros (unsigned).
REQ-030 Stores SHALL drive mem_be for the addressed bytes only and replicate ex_wdata's low bytes across all lanes; wb_regwrite SHALL be 0.
REQ-031 Misalignment (half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0, or dword at DATA_W=32) SHALL skip memory, produce wb_valid with wb_regwrite=0 after 1 cycle, and pulse misalign with it.
REQ-032 Accepting a non-squashed instruction with ex_branch=1 SHALL load the shadow counter with SHADOW_DEPTH.
REQ-033 Each later accepted instruction SHALL decrement a nonzero counter; while it is nonzero, accepted instructions SHALL be squashed: no mem_req, wb_regwrite=0, and ex_branch ignored.
REQ-034 branch_shadow SHALL equal (counter!=0).
REQ-035 mem_ack outside BUSY SHALL be ignored.
REQ-036 With ex_valid=0, wb_valid SHALL be 0 on the next cycle and the counter SHALL hold.

Reset
REQ-037 rst SHALL force IDLE, counter=0, all outputs 0 (including mem_req), on the next edge, even in BUSY; the interrupted access SHALL produce no wb_valid.

Structure
REQ-038 Package dlx_mem_pkg SHALL hold the size encodings and FSM state enum.
REQ-039 Lane select, extension and byte-enable generation SHALL be one combinational sub-module, dlx_mem_lane_align.

Verification
REQ-040 lb at 0x1003, signed, rdata=0x80xxxxxx, ack after 2 wait cycles -> wb_rdata=0xFFFFFF80, stall high 3 cycles.
REQ-041 sh 0x1234ABCD to 0x2002 -> mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x2000.
REQ-042 lw at 0x1001 -> no mem_req, misalign pulse, wb_regwrite=0.
REQ-043 beq then 4 stores, SHADOW_DEPTH=3 -> only the 4th store issues mem_req.
REQ-044 rst asserted in BUSY -> mem_req 0 next cycle, no wb_valid.
REQ-045 DATA_W=64, ld at 0x8 -> mem_be=0xFF, wb_rdata=mem_rdata.

Source files
------------

// File: rtl/dlx_mem_pkg.sv
// Shared encodings for the DLX memory stage: access sizes, FSM states, counter width.
package dlx_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Branch-shadow counter width; holds SHADOW_DEPTH up to 15.
  localparam int CNT_W = 4;

  // Number of bytes touched by an access of the given size.
  function automatic int size_bytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

endpackage

// File: rtl/dlx_mem_lane_align.sv
// Combinational lane handling: byte enables, store-data replication,
// load lane select with sign/zero extension, and alignment check.
module dlx_mem_lane_align
  import dlx_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB     = DATA_W / 8,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  off,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              misalign
);

  logic [DATA_W-1:0] shifted;
  logic              msb;
  logic              sign;
  int                sb;
  int                o;

  // Decode size/offset into enables, replicated store data, extended load data.
  always_comb begin
    sb        = size_bytes(size);
    o         = int'(off);
    be        = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    msb       = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i >= o && i < o + sb) be[i] = 1'b1;
      wdata_rep[8*i +: 8] = wdata[8*(i % sb) +: 8];
    end
    // The addressed lane is moved down to bit 0 before extension.
    shifted = rdata >> {off, 3'b000};
    case (size)
      SZ_BYTE: msb = shifted[7];
      SZ_HALF: msb = shifted[15];
      SZ_WORD: msb = shifted[31];
      default: msb = shifted[DATA_W-1];
    endcase
    sign = ~is_unsigned & msb;
    for (int j = 0; j < DATA_W; j++) begin
      rdata_ext[j] = (j < 8 * sb) ? shifted[j] : sign;
    end
    case (size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = off[0];
      SZ_WORD: misalign = (off[1:0] != 2'b00);
      default: misalign = (DATA_W == 32) || (off != '0);
    endcase
  end

endmodule

// File: rtl/dlx_mem_stage_p.sv
// DLX MEM pipeline stage: issues one load/store at a time to a word-wide
// memory, stalls EX while waiting for mem_ack, squashes the branch shadow,
// and presents the retired instruction on the registered wb_* outputs.
// Handshake: EX hands over an instruction on any rising edge where
// ex_valid=1 and stall=0; stall is high exactly while an access is in flight,
// and mem_* stay constant from the cycle after acceptance through the mem_ack
// cycle.
module dlx_mem_stage_p
  import dlx_mem_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int REG_W        = 5,
  parameter int SHADOW_DEPTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic                ex_mem_rd,
  input  logic                ex_mem_wr,
  input  logic [1:0]          ex_size,
  input  logic                ex_unsigned,
  input  logic [ADDR_W-1:0]   ex_addr,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_memtoreg,
  input  logic                ex_regwrite,
  input  logic                ex_branch,
  input  logic [REG_W-1:0]    ex_towrite,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall,
  output logic                wb_valid,
  output logic                wb_memtoreg,
  output logic                wb_regwrite,
  output logic [REG_W-1:0]    wb_towrite,
  output logic [DATA_W-1:0]   wb_result,
  output logic [DATA_W-1:0]   wb_rdata,
  output logic                branch_shadow,
  output logic                misalign
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [NB-1:0]      mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  // Fields of the in-flight access, needed again when mem_ack arrives.
  logic [1:0]         p_size_q, p_size_d;
  logic [OFF_W-1:0]   p_off_q, p_off_d;
  logic               p_uns_q, p_uns_d;
  logic               p_load_q, p_load_d;
  logic               p_memtoreg_q, p_memtoreg_d;
  logic               p_regwrite_q, p_regwrite_d;
  logic [REG_W-1:0]   p_towrite_q, p_towrite_d;
  logic [ADDR_W-1:0]  p_addr_q, p_addr_d;
  logic               wb_valid_q, wb_valid_d;
  logic               wb_memtoreg_q, wb_memtoreg_d;
  logic               wb_regwrite_q, wb_regwrite_d;
  logic [REG_W-1:0]   wb_towrite_q, wb_towrite_d;
  logic [DATA_W-1:0]  wb_result_q, wb_result_d;
  logic [DATA_W-1:0]  wb_rdata_q, wb_rdata_d;
  logic               misalign_q, misalign_d;

  logic               busy;
  logic [1:0]         a_size;
  logic [OFF_W-1:0]   a_off;
  logic               a_uns;
  logic [NB-1:0]      la_be;
  logic [DATA_W-1:0]  la_wdata;
  logic [DATA_W-1:0]  la_rdata;
  logic               la_mis;

  assign busy = (state_q == ST_BUSY);

  // One aligner serves both phases: EX fields at acceptance (only possible
  // in IDLE), the captured fields while the access is in flight.
  assign a_size = busy ? p_size_q : ex_size;
  assign a_off  = busy ? p_off_q  : ex_addr[OFF_W-1:0];
  assign a_uns  = busy ? p_uns_q  : ex_unsigned;

  dlx_mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size        (a_size),
    .off         (a_off),
    .is_unsigned (a_uns),
    .wdata       (ex_wdata),
    .rdata       (mem_rdata),
    .be          (la_be),
    .wdata_rep   (la_wdata),
    .rdata_ext   (la_rdata),
    .misalign    (la_mis)
  );

  // Next-state logic for the FSM, shadow counter, memory port and WB register.
  always_comb begin
    logic squash;
    logic mem_op;
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_be_d      = mem_be_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    p_size_d      = p_size_q;
    p_off_d       = p_off_q;
    p_uns_d       = p_uns_q;
    p_load_d      = p_load_q;
    p_memtoreg_d  = p_memtoreg_q;
    p_regwrite_d  = p_regwrite_q;
    p_towrite_d   = p_towrite_q;
    p_addr_d      = p_addr_q;
    wb_valid_d    = 1'b0;
    wb_memtoreg_d = wb_memtoreg_q;
    wb_regwrite_d = wb_regwrite_q;
    wb_towrite_d  = wb_towrite_q;
    wb_result_d   = wb_result_q;
    wb_rdata_d    = wb_rdata_q;
    misalign_d    = 1'b0;
    squash        = (cnt_q != '0);
    mem_op        = (ex_mem_rd | ex_mem_wr) & ~squash;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (squash)         cnt_d = cnt_q - 1'b1;
          else if (ex_branch) cnt_d = CNT_W'(SHADOW_DEPTH);
          if (mem_op && !la_mis) begin
            state_d      = ST_BUSY;
            mem_req_d    = 1'b1;
            mem_we_d     = ex_mem_wr;
            mem_be_d     = la_be;
            mem_addr_d   = {ex_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata_d  = la_wdata;
            p_size_d     = ex_size;
            p_off_d      = ex_addr[OFF_W-1:0];
            p_uns_d      = ex_unsigned;
            p_load_d     = ~ex_mem_wr;
            p_memtoreg_d = ex_memtoreg;
            p_regwrite_d = ex_regwrite;
            p_towrite_d  = ex_towrite;
            p_addr_d     = ex_addr;
          end else begin
            // Non-memory, squashed or misaligned: retire straight away.
            wb_valid_d    = 1'b1;
            wb_memtoreg_d = ex_memtoreg & ~squash;
            wb_regwrite_d = ex_regwrite & ~squash & ~(ex_mem_rd | ex_mem_wr);
            wb_towrite_d  = ex_towrite;
            wb_result_d   = DATA_W'(ex_addr);
            wb_rdata_d    = '0;
            misalign_d    = mem_op & la_mis;
          end
        end
      end
      default: begin
        if (mem_ack) begin
          state_d       = ST_IDLE;
          mem_req_d     = 1'b0;
          mem_we_d      = 1'b0;
          mem_be_d      = '0;
          mem_addr_d    = '0;
          mem_wdata_d   = '0;
          wb_valid_d    = 1'b1;
          wb_memtoreg_d = p_memtoreg_q;
          wb_regwrite_d = p_regwrite_q & p_load_q;
          wb_towrite_d  = p_towrite_q;
          wb_result_d   = DATA_W'(p_addr_q);
          wb_rdata_d    = p_load_q ? la_rdata : '0;
        end
      end
    endcase
  end

  // All state registers; reset wins over an in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_be_q      <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      p_size_q      <= '0;
      p_off_q       <= '0;
      p_uns_q       <= 1'b0;
      p_load_q      <= 1'b0;
      p_memtoreg_q  <= 1'b0;
      p_regwrite_q  <= 1'b0;
      p_towrite_q   <= '0;
      p_addr_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_towrite_q  <= '0;
      wb_result_q   <= '0;
      wb_rdata_q    <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_be_q      <= mem_be_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      p_size_q      <= p_size_d;
      p_off_q       <= p_off_d;
      p_uns_q       <= p_uns_d;
      p_load_q      <= p_load_d;
      p_memtoreg_q  <= p_memtoreg_d;
      p_regwrite_q  <= p_regwrite_d;
      p_towrite_q   <= p_towrite_d;
      p_addr_q      <= p_addr_d;
      wb_valid_q    <= wb_valid_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_towrite_q  <= wb_towrite_d;
      wb_result_q   <= wb_result_d;
      wb_rdata_q    <= wb_rdata_d;
      misalign_q    <= misalign_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_be        = mem_be_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign stall         = busy;
  assign wb_valid      = wb_valid_q;
  assign wb_memtoreg   = wb_memtoreg_q;
  assign wb_regwrite   = wb_regwrite_q;
  assign wb_towrite    = wb_towrite_q;
  assign wb_result     = wb_result_q;
  assign wb_rdata      = wb_rdata_q;
  assign branch_shadow = (cnt_q != '0);
  assign misalign      = misalign_q;

endmodule

// File: tb/tb_dlx_mem_stage_p.sv
// Directed bench for dlx_mem_stage_p: a 32-bit instance for the main
// scenarios and a 64-bit instance for doubleword accesses.
module tb_dlx_mem_stage_p;

  logic        clk = 1'b0;
  logic        rst;
  int          n_cmp = 0;
  int          n_err = 0;

  // 32-bit instance signals
  logic        ex_valid, ex_mem_rd, ex_mem_wr, ex_unsigned;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic        ex_memtoreg, ex_regwrite, ex_branch;
  logic [4:0]  ex_towrite;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, stall;
  logic        wb_valid, wb_memtoreg, wb_regwrite;
  logic [4:0]  wb_towrite;
  logic [31:0] wb_result, wb_rdata;
  logic        branch_shadow, misalign;

  // 64-bit instance signals
  logic        d_ex_valid, d_ex_mem_rd, d_ex_unsigned;
  logic [1:0]  d_ex_size;
  logic [31:0] d_ex_addr;
  logic        d_mem_req, d_mem_we;
  logic [7:0]  d_mem_be;
  logic [31:0] d_mem_addr;
  logic [63:0] d_mem_wdata, d_mem_rdata, d_wb_result, d_wb_rdata;
  logic        d_mem_ack, d_stall, d_wb_valid, d_wb_memtoreg, d_wb_regwrite;
  logic [4:0]  d_wb_towrite;
  logic        d_branch_shadow, d_misalign;

  always #5 clk = ~clk;

  dlx_mem_stage_p dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_branch(ex_branch), .ex_towrite(ex_towrite),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .wb_valid(wb_valid), .wb_memtoreg(wb_memtoreg),
    .wb_regwrite(wb_regwrite), .wb_towrite(wb_towrite), .wb_result(wb_result),
    .wb_rdata(wb_rdata), .branch_shadow(branch_shadow), .misalign(misalign)
  );

  dlx_mem_stage_p #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .ex_valid(d_ex_valid), .ex_mem_rd(d_ex_mem_rd),
    .ex_mem_wr(1'b0), .ex_size(d_ex_size), .ex_unsigned(d_ex_unsigned),
    .ex_addr(d_ex_addr), .ex_wdata(64'h0), .ex_memtoreg(1'b1),
    .ex_regwrite(1'b1), .ex_branch(1'b0), .ex_towrite(5'd9),
    .mem_req(d_mem_req), .mem_we(d_mem_we), .mem_be(d_mem_be),
    .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata), .mem_rdata(d_mem_rdata),
    .mem_ack(d_mem_ack), .stall(d_stall), .wb_valid(d_wb_valid),
    .wb_memtoreg(d_wb_memtoreg), .wb_regwrite(d_wb_regwrite),
    .wb_towrite(d_wb_towrite), .wb_result(d_wb_result), .wb_rdata(d_wb_rdata),
    .branch_shadow(d_branch_shadow), .misalign(d_misalign)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_mem_rd = 0; ex_mem_wr = 0; ex_size = 2'b10; ex_unsigned = 0;
    ex_addr = '0; ex_wdata = '0; ex_memtoreg = 0; ex_regwrite = 0; ex_branch = 0;
    ex_towrite = '0; mem_rdata = '0; mem_ack = 0;
    d_ex_valid = 0; d_ex_mem_rd = 0; d_ex_size = 2'b11; d_ex_unsigned = 0;
    d_ex_addr = '0; d_mem_rdata = '0; d_mem_ack = 0;
  endtask

  // Present one instruction from EX (held until the caller changes it).
  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic rw,
                       input logic br, input logic [4:0] rd_idx);
    ex_valid = 1; ex_mem_rd = rd; ex_mem_wr = wr; ex_size = sz; ex_unsigned = uns;
    ex_addr = addr; ex_wdata = wdata; ex_regwrite = rw; ex_memtoreg = rd;
    ex_branch = br; ex_towrite = rd_idx;
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    n_cmp++; if ({stall, branch_shadow, misalign} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {stall, branch_shadow, misalign}); end
    rst = 0;
    step();
  endtask

  task automatic test_alu();
    drive(0, 0, 2'b10, 0, 32'hDEADBEEF, 32'h0, 1, 0, 5'd7);
    step();
    ex_valid = 0;
    n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL alu_wb_valid: got %b want 1", wb_valid); end
    n_cmp++; if (wb_result !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_result: got %h want deadbeef", wb_result); end
    n_cmp++; if ({wb_regwrite, wb_towrite} !== {1'b1, 5'd7}) begin n_err++; $display("FAIL alu_regwrite: got %b/%0d want 1/7", wb_regwrite, wb_towrite); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL alu_mem_req: got %b want 0", mem_req); end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL alu_idle_wb: got %b want 0", wb_valid); end
  endtask

  task automatic test_load_byte();
    int stall_cycles = 0;
    drive(1, 0, 2'b00, 0, 32'h0000_1003, 32'h0, 1, 0, 5'd3);
    mem_rdata = 32'h8012_3456;
    step();
    ex_valid = 0;
    n_cmp++; if ({mem_req, mem_we, mem_be} !== 6'b10_1000) begin n_err++; $display("FAIL lb_req: got req=%b we=%b be=%b want 1 0 1000", mem_req, mem_we, mem_be); end
    n_cmp++; if (mem_addr !== 32'h0000_1000) begin n_err++; $display("FAIL lb_addr: got %h want 00001000", mem_addr); end
    for (int c = 1; c <= 3; c++) begin
      if (stall) stall_cycles++;
      if (c < 3 && wb_valid !== 1'b0) begin n_err++; $display("FAIL lb_early_wb: got wb_valid=1 at wait %0d want 0", c); end
      mem_ack = (c == 3);
      step();
    end
    mem_ack = 0;
    n_cmp++; if (stall_cycles != 3) begin n_err++; $display("FAIL lb_stall_len: got %0d want 3", stall_cycles); end
    n_cmp++; if ({wb_valid, wb_regwrite, wb_memtoreg} !== 3'b111) begin n_err++; $display("FAIL lb_wb_ctrl: got %b want 111", {wb_valid, wb_regwrite, wb_memtoreg}); end
    n_cmp++; if (wb_rdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_rdata: got %h want ffffff80", wb_rdata); end
    n_cmp++; if ({stall, mem_req} !== 2'b00) begin n_err++; $display("FAIL lb_release: got stall=%b req=%b want 0 0", stall, mem_req); end
    // A stray ack while idle must be ignored.
    mem_ack = 1;
    step();
    mem_ack = 0;
    n_cmp++; if ({wb_valid, stall} !== 2'b00) begin n_err++; $display("FAIL stray_ack: got wb=%b stall=%b want 0 0", wb_valid, stall); end
  endtask

  task automatic test_load_half();
    drive(1, 0, 2'b01, 1, 32'h0000_3002, 32'h0, 1, 0, 5'd4);
    mem_rdata = 32'h8765_4321;
    step();
    ex_valid = 0; mem_ack = 1;
    step();
    mem_ack = 0;
    n_cmp++; if (wb_rdata !== 32'h0000_8765) begin n_err++; $display("FAIL lhu_rdata: got %h want 00008765", wb_rdata); end
    drive(1, 0, 2'b01, 0, 32'h0000_3000, 32'h0, 1, 0, 5'd4);
    mem_rdata = 32'h1234_F00D;
    step();
    ex_valid = 0;
    n_cmp++; if (mem_be !== 4'b0011) begin n_err++; $display("FAIL lh_be: got %b want 0011", mem_be); end
    mem_ack = 1;
    step();
    mem_ack = 0;
    n_cmp++; if (wb_rdata !== 32'hFFFF_F00D) begin n_err++; $display("FAIL lh_rdata: got %h want fffff00d", wb_rdata); end
  endtask

  task automatic test_store_half();
    drive(0, 1, 2'b01, 0, 32'h0000_2002, 32'h1234_ABCD, 1, 0, 5'd5);
    step();
    ex_valid = 0;
    n_cmp++; if ({mem_req, mem_we, mem_be} !== 6'b11_1100) begin n_err++; $display("FAIL sh_req: got req=%b we=%b be=%b want 1 1 1100", mem_req, mem_we, mem_be); end
    n_cmp++; if (mem_wdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_wdata: got %h want abcdabcd", mem_wdata); end
    n_cmp++; if (mem_addr !== 32'h0000_2000) begin n_err++; $display("FAIL sh_addr: got %h want 00002000", mem_addr); end
    mem_ack = 1;
    step();
    mem_ack = 0;
    n_cmp++; if ({wb_valid, wb_regwrite} !== 2'b10) begin n_err++; $display("FAIL sh_wb: got valid=%b rw=%b want 1 0", wb_valid, wb_regwrite); end
  endtask

  task automatic test_misalign();
    drive(1, 0, 2'b10, 0, 32'h0000_1001, 32'h0, 1, 0, 5'd6);
    step();
    ex_valid = 0;
    n_cmp++; if ({mem_req, stall} !== 2'b00) begin n_err++; $display("FAIL lw_mis_req: got req=%b stall=%b want 0 0", mem_req, stall); end
    n_cmp++; if ({misalign, wb_valid, wb_regwrite} !== 3'b110) begin n_err++; $display("FAIL lw_mis_wb: got %b want 110", {misalign, wb_valid, wb_regwrite}); end
    step();
    n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("FAIL lw_mis_pulse: got %b want 0", misalign); end
    // Doubleword on a 32-bit stage is always misaligned.
    drive(1, 0, 2'b11, 0, 32'h0000_0008, 32'h0, 1, 0, 5'd6);
    step();
    ex_valid = 0;
    n_cmp++; if ({mem_req, misalign, wb_regwrite} !== 3'b010) begin n_err++; $display("FAIL ld32_mis: got %b want 010", {mem_req, misalign, wb_regwrite}); end
    step();
  endtask

  task automatic test_branch_shadow();
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0, 0, 1, 5'd0);
    step();
    ex_valid = 0;
    n_cmp++; if (branch_shadow !== 1'b1) begin n_err++; $display("FAIL br_shadow_on: got %b want 1", branch_shadow); end
    step();
    n_cmp++; if (branch_shadow !== 1'b1) begin n_err++; $display("FAIL br_shadow_hold: got %b want 1", branch_shadow); end
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, 2'b10, 0, 32'h0000_4000, 32'h1111_0000 + k, 1, 0, 5'd1);
      step();
      ex_valid = 0;
      if (k < 4) begin
        n_cmp++; if ({mem_req, wb_valid, wb_regwrite} !== 3'b010) begin n_err++; $display("FAIL br_squash_%0d: got %b want 010", k, {mem_req, wb_valid, wb_regwrite}); end
      end else begin
        n_cmp++; if ({mem_req, mem_wdata} !== {1'b1, 32'h1111_0004}) begin n_err++; $display("FAIL br_issue_4: got req=%b wdata=%h want 1 11110004", mem_req, mem_wdata); end
      end
    end
    n_cmp++; if (branch_shadow !== 1'b0) begin n_err++; $display("FAIL br_shadow_off: got %b want 0", branch_shadow); end
    mem_ack = 1;
    step();
    mem_ack = 0;
  endtask

  task automatic test_reset_busy();
    drive(1, 0, 2'b10, 0, 32'h0000_5000, 32'h0, 1, 0, 5'd2);
    step();
    ex_valid = 0;
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rb_busy: got %b want 1", mem_req); end
    rst = 1; mem_ack = 1;
    step();
    n_cmp++; if ({mem_req, stall, wb_valid} !== 3'b000) begin n_err++; $display("FAIL rb_reset: got %b want 000", {mem_req, stall, wb_valid}); end
    rst = 0; mem_ack = 0;
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rb_no_wb: got %b want 0", wb_valid); end
  endtask

  task automatic test_dword64();
    d_ex_valid = 1; d_ex_mem_rd = 1; d_ex_size = 2'b11; d_ex_addr = 32'h8;
    d_mem_rdata = 64'h8123_4567_89AB_CDEF;
    step();
    d_ex_valid = 0;
    n_cmp++; if ({d_mem_req, d_mem_be} !== {1'b1, 8'hFF}) begin n_err++; $display("FAIL ld64_be: got req=%b be=%h want 1 ff", d_mem_req, d_mem_be); end
    n_cmp++; if (d_mem_addr !== 32'h8) begin n_err++; $display("FAIL ld64_addr: got %h want 00000008", d_mem_addr); end
    d_mem_ack = 1;
    step();
    d_mem_ack = 0;
    n_cmp++; if ({d_wb_valid, d_wb_rdata} !== {1'b1, 64'h8123_4567_89AB_CDEF}) begin n_err++; $display("FAIL ld64_rdata: got v=%b %h want 1 8123456789abcdef", d_wb_valid, d_wb_rdata); end
    // Upper-lane signed word on the 64-bit stage.
    d_ex_valid = 1; d_ex_size = 2'b10; d_ex_addr = 32'hC;
    d_mem_rdata = 64'h8000_0000_0000_0000;
    step();
    d_ex_valid = 0; d_mem_ack = 1;
    step();
    d_mem_ack = 0;
    n_cmp++; if (d_wb_rdata !== 64'hFFFF_FFFF_8000_0000) begin n_err++; $display("FAIL lw64_rdata: got %h want ffffffff80000000", d_wb_rdata); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu();
    test_load_byte();
    test_load_half();
    test_store_half();
    test_misalign();
    test_branch_shadow();
    test_reset_busy();
    test_dword64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
